// File: rtl/ppu_cpu_port.sv
// CPU-side register port of the PPU ($2000-$3FFF mirror): control/mask/scroll registers,
// VRAM address and PPUDATA read buffer, status flags with NMI, and the OAM address/data path.
module ppu_cpu_port #(
    parameter int unsigned VRAM_AW = 14,
    parameter int unsigned INC_BIG = 32
) (
    input  logic               ph0,
    input  logic               reset,
    input  logic               cs,
    input  logic               access,
    input  logic [2:0]         a,
    input  logic               rw,
    input  logic [7:0]         d_in,
    output logic [7:0]         d_out,
    output logic               d_oe,
    output logic [7:0]         ctrl,
    output logic [7:0]         mask,
    output logic [7:0]         scroll_x,
    output logic [7:0]         scroll_y,
    input  logic               vblank_set,
    input  logic               vblank_clr,
    input  logic               spr0_hit,
    input  logic               spr_ovf,
    output logic               nmi_n,
    output logic [VRAM_AW-1:0] vram_addr,
    output logic [7:0]         vram_wdata,
    output logic               vram_we,
    output logic               vram_re,
    input  logic [7:0]         vram_rdata,
    input  logic               vram_rvalid,
    output logic [7:0]         oam_addr,
    output logic [7:0]         oam_wdata,
    output logic               oam_we,
    input  logic [7:0]         oam_rdata
);

    localparam int unsigned T_W = 15;

    logic [VRAM_AW-1:0] v;
    logic [T_W-1:0]     t;
    logic               w;
    logic [7:0]         rd_buf;
    logic [7:0]         io_latch;
    logic               vblank;
    logic               spr0;
    logic               ovf;

    logic               acc;
    logic               rd_acc;
    logic               wr_acc;
    logic [VRAM_AW-1:0] inc;
    logic               vblank_nx;
    logic [7:0]         ctrl_nx;
    logic [T_W-1:0]     t_nx;

    // Access decode, read mux and same-cycle strobes; reset masks any access in flight.
    always_comb begin
        acc        = cs & access & ~reset;
        rd_acc     = acc & rw;
        wr_acc     = acc & ~rw;
        inc        = ctrl[2] ? VRAM_AW'(INC_BIG) : VRAM_AW'(1);

        d_out = 8'h00;
        if (rd_acc) begin
            case (a)
                3'd2:    d_out = {vblank, spr0, ovf, io_latch[4:0]};
                3'd4:    d_out = oam_rdata;
                3'd7:    d_out = rd_buf;
                default: d_out = io_latch;
            endcase
        end
        d_oe       = rd_acc;

        vram_addr  = v;
        vram_we    = wr_acc && (a == 3'd7);
        vram_re    = rd_acc && (a == 3'd7);
        vram_wdata = vram_we ? d_in : 8'h00;
        oam_we     = wr_acc && (a == 3'd4);
        oam_wdata  = oam_we ? d_in : 8'h00;

        ctrl_nx = (wr_acc && (a == 3'd0)) ? d_in : ctrl;

        // A status read racing vblank_set wins, so the flag never shows up and NMI is not raised.
        if (vblank_clr)                    vblank_nx = 1'b0;
        else if (rd_acc && (a == 3'd2))    vblank_nx = 1'b0;
        else if (vblank_set)               vblank_nx = 1'b1;
        else                               vblank_nx = vblank;

        t_nx = t;
        if (wr_acc && (a == 3'd6)) begin
            t_nx = w ? {t[14:8], d_in} : {1'b0, d_in[5:0], t[7:0]};
        end
    end

    // Register state; every side effect of an access lands on the edge closing its cycle.
    always_ff @(posedge ph0) begin
        if (reset) begin
            ctrl     <= 8'h00;
            mask     <= 8'h00;
            scroll_x <= 8'h00;
            scroll_y <= 8'h00;
            oam_addr <= 8'h00;
            v        <= '0;
            t        <= '0;
            w        <= 1'b0;
            rd_buf   <= 8'h00;
            io_latch <= 8'h00;
            vblank   <= 1'b0;
            spr0     <= 1'b0;
            ovf      <= 1'b0;
            nmi_n    <= 1'b1;
        end else begin
            ctrl   <= ctrl_nx;
            vblank <= vblank_nx;
            spr0   <= vblank_clr ? 1'b0 : (spr0 | spr0_hit);
            ovf    <= vblank_clr ? 1'b0 : (ovf | spr_ovf);
            nmi_n  <= ~(vblank_nx & ctrl_nx[7]);
            t      <= t_nx;
            if (vram_rvalid) rd_buf <= vram_rdata;

            if (wr_acc) begin
                io_latch <= d_in;
                case (a)
                    3'd1: mask     <= d_in;
                    3'd3: oam_addr <= d_in;
                    3'd4: oam_addr <= oam_addr + 8'd1;
                    3'd5: begin
                        if (w) scroll_y <= d_in;
                        else   scroll_x <= d_in;
                        w <= ~w;
                    end
                    3'd6: begin
                        if (w) v <= VRAM_AW'(t_nx);
                        w <= ~w;
                    end
                    3'd7: v <= v + inc;
                    default: ;
                endcase
            end

            if (rd_acc) begin
                io_latch <= d_out;
                case (a)
                    3'd2:    w <= 1'b0;
                    3'd7:    v <= v + inc;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ppu_cpu_port.sv
// Directed bench for ppu_cpu_port: read data and strobes are checked against a scoreboard
// of expected values queued by the stimulus; register outputs are checked between accesses.
module tb_ppu_cpu_port;

    logic        ph0 = 1'b0;
    logic        reset = 1'b1;
    logic        cs = 1'b0;
    logic        access = 1'b0;
    logic [2:0]  a = 3'd0;
    logic        rw = 1'b1;
    logic [7:0]  d_in = 8'h00;
    logic [7:0]  d_out;
    logic        d_oe;
    logic [7:0]  ctrl, mask, scroll_x, scroll_y;
    logic        vblank_set = 1'b0, vblank_clr = 1'b0, spr0_hit = 1'b0, spr_ovf = 1'b0;
    logic        nmi_n;
    logic [13:0] vram_addr;
    logic [7:0]  vram_wdata;
    logic        vram_we, vram_re;
    logic [7:0]  vram_rdata = 8'h00;
    logic        vram_rvalid = 1'b0;
    logic [7:0]  oam_addr, oam_wdata;
    logic        oam_we;
    logic [7:0]  oam_rdata;

    int n_pass = 0;
    int n_total = 0;
    int n_fail = 0;

    logic [31:0] exp_rd[$];
    logic [31:0] exp_vw[$];
    logic [31:0] exp_vr[$];
    logic [31:0] exp_ow[$];
    logic [7:0]  vdat_q[$];

    ppu_cpu_port #(.VRAM_AW(14), .INC_BIG(32)) dut (
        .ph0(ph0), .reset(reset), .cs(cs), .access(access), .a(a), .rw(rw),
        .d_in(d_in), .d_out(d_out), .d_oe(d_oe), .ctrl(ctrl), .mask(mask),
        .scroll_x(scroll_x), .scroll_y(scroll_y), .vblank_set(vblank_set),
        .vblank_clr(vblank_clr), .spr0_hit(spr0_hit), .spr_ovf(spr_ovf), .nmi_n(nmi_n),
        .vram_addr(vram_addr), .vram_wdata(vram_wdata), .vram_we(vram_we), .vram_re(vram_re),
        .vram_rdata(vram_rdata), .vram_rvalid(vram_rvalid), .oam_addr(oam_addr),
        .oam_wdata(oam_wdata), .oam_we(oam_we), .oam_rdata(oam_rdata)
    );

    always #5 ph0 = ~ph0;

    // OAM contents seen by the port: a fixed function of the address.
    assign oam_rdata = oam_addr ^ 8'hA5;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // VRAM responds one cycle after a read strobe.
    always @(posedge ph0) begin
        if (vram_re) begin
            #1;
            vram_rdata  = (vdat_q.size() != 0) ? vdat_q.pop_front() : 8'hEE;
            vram_rvalid = 1'b1;
        end else begin
            #1;
            vram_rvalid = 1'b0;
        end
    end

    // Scoreboard: compare everything the DUT presents mid-cycle against queued expectations.
    always @(negedge ph0) begin
        if (d_oe) begin
            check("read_expected", 32'(exp_rd.size() != 0), 32'd1);
            if (exp_rd.size() != 0) check("d_out", 32'(d_out), exp_rd.pop_front());
        end
        if (vram_we) begin
            check("vram_we_expected", 32'(exp_vw.size() != 0), 32'd1);
            if (exp_vw.size() != 0) check("vram_write", 32'({vram_addr, vram_wdata}), exp_vw.pop_front());
        end
        if (vram_re) begin
            check("vram_re_expected", 32'(exp_vr.size() != 0), 32'd1);
            if (exp_vr.size() != 0) check("vram_read_addr", 32'(vram_addr), exp_vr.pop_front());
        end
        if (oam_we) begin
            check("oam_we_expected", 32'(exp_ow.size() != 0), 32'd1);
            if (exp_ow.size() != 0) check("oam_write", 32'({oam_addr, oam_wdata}), exp_ow.pop_front());
        end
        if (vram_we && vram_re) check("vram_strobes_exclusive", 32'd1, 32'd0);
    end

    task automatic acc(input logic [2:0] ra, input logic rwv, input logic [7:0] data);
        @(posedge ph0); #1;
        cs = 1'b1; access = 1'b1; a = ra; rw = rwv; d_in = data;
        #2 check("d_oe", 32'(d_oe), 32'(rwv & ~reset));
        @(posedge ph0); #1;
        cs = 1'b0; access = 1'b0; rw = 1'b1; d_in = 8'h00;
    endtask

    task automatic wr(input logic [2:0] ra, input logic [7:0] data);
        acc(ra, 1'b0, data);
    endtask

    task automatic rd(input logic [2:0] ra, input logic [7:0] exp);
        exp_rd.push_back(32'(exp));
        acc(ra, 1'b1, 8'h00);
    endtask

    task automatic pulse(input logic vs, input logic vc, input logic s0, input logic ov);
        @(posedge ph0); #1;
        vblank_set = vs; vblank_clr = vc; spr0_hit = s0; spr_ovf = ov;
        @(posedge ph0); #1;
        vblank_set = 1'b0; vblank_clr = 1'b0; spr0_hit = 1'b0; spr_ovf = 1'b0;
    endtask

    initial begin
        #200000;
        $fatal(1, "FAIL timeout: bench did not finish");
    end

    initial begin
        repeat (2) @(posedge ph0);
        #1;
        check("rst_ctrl", 32'(ctrl), 32'h00);
        check("rst_mask", 32'(mask), 32'h00);
        check("rst_scroll", 32'({scroll_x, scroll_y}), 32'h0000);
        check("rst_nmi_n", 32'(nmi_n), 32'd1);
        check("rst_d_oe", 32'(d_oe), 32'd0);
        check("rst_vram_addr", 32'(vram_addr), 32'h0000);
        check("rst_oam_addr", 32'(oam_addr), 32'h00);
        check("rst_strobes", 32'({vram_we, vram_re, oam_we}), 32'd0);

        // An OAM data write while reset is held must be discarded.
        wr(3'd4, 8'hFF);
        reset = 1'b0;
        check("rst_abort_oam_addr", 32'(oam_addr), 32'h00);

        rd(3'd0, 8'h00);

        wr(3'd6, 8'h21);
        wr(3'd6, 8'h08);
        check("v_after_2006", 32'(vram_addr), 32'h2108);
        exp_vw.push_back(32'h002108AB);
        wr(3'd7, 8'hAB);
        check("v_inc1", 32'(vram_addr), 32'h2109);

        wr(3'd0, 8'h04);
        check("ctrl_04", 32'(ctrl), 32'h04);
        wr(3'd6, 8'h3F);
        wr(3'd6, 8'hF0);
        check("v_3ff0", 32'(vram_addr), 32'h3FF0);
        vdat_q.push_back(8'h11);
        vdat_q.push_back(8'h22);
        exp_vr.push_back(32'h3FF0);
        rd(3'd7, 8'h00);
        check("v_wrap", 32'(vram_addr), 32'h0010);
        exp_vr.push_back(32'h0010);
        rd(3'd7, 8'h11);
        check("v_inc32", 32'(vram_addr), 32'h0030);
        exp_vr.push_back(32'h0030);
        rd(3'd7, 8'h22);

        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        check("nmi_idle_ctrl7_0", 32'(nmi_n), 32'd1);
        wr(3'd0, 8'h80);
        check("ctrl_80", 32'(ctrl), 32'h80);
        check("nmi_assert", 32'(nmi_n), 32'd0);
        wr(3'd5, 8'h33);
        check("scroll_x_33", 32'(scroll_x), 32'h33);
        rd(3'd2, 8'h93);
        check("nmi_release_on_status", 32'(nmi_n), 32'd1);
        wr(3'd5, 8'h44);
        check("w_cleared_scroll_x", 32'(scroll_x), 32'h44);
        check("w_cleared_scroll_y", 32'(scroll_y), 32'h00);

        // Status read in the same cycle as vblank_set suppresses the flag.
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        exp_rd.push_back(32'h44);
        @(posedge ph0); #1;
        cs = 1'b1; access = 1'b1; a = 3'd2; rw = 1'b1; vblank_set = 1'b1;
        @(posedge ph0); #1;
        cs = 1'b0; access = 1'b0; vblank_set = 1'b0;
        check("suppress_nmi_n", 32'(nmi_n), 32'd1);
        @(posedge ph0); #1;
        check("suppress_nmi_n_later", 32'(nmi_n), 32'd1);
        rd(3'd2, 8'h44);

        pulse(1'b1, 1'b1, 1'b0, 1'b1);
        check("clear_wins_nmi_n", 32'(nmi_n), 32'd1);
        rd(3'd2, 8'h04);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        rd(3'd2, 8'h24);

        wr(3'd3, 8'hFF);
        exp_ow.push_back(32'h0000FF5A);
        wr(3'd4, 8'h5A);
        check("oam_addr_wrap", 32'(oam_addr), 32'h00);
        rd(3'd4, 8'hA5);
        check("oam_read_no_inc", 32'(oam_addr), 32'h00);

        rd(3'd1, 8'hA5);
        wr(3'd2, 8'h3C);
        rd(3'd1, 8'h3C);
        check("mask_untouched", 32'(mask), 32'h00);
        wr(3'd1, 8'h1E);
        check("mask_1e", 32'(mask), 32'h1E);
        rd(3'd0, 8'h1E);

        wr(3'd5, 8'h10);
        check("scroll_x_10", 32'(scroll_x), 32'h10);
        @(posedge ph0); #1 reset = 1'b1;
        @(posedge ph0); #1 reset = 1'b0;
        check("rst2_ctrl", 32'(ctrl), 32'h00);
        check("rst2_scroll_x", 32'(scroll_x), 32'h00);
        wr(3'd5, 8'h55);
        check("rst2_w_scroll_x", 32'(scroll_x), 32'h55);
        check("rst2_w_scroll_y", 32'(scroll_y), 32'h00);

        repeat (2) @(posedge ph0);
        #1;
        check("rd_queue_drained", 32'(exp_rd.size()), 32'd0);
        check("vw_queue_drained", 32'(exp_vw.size()), 32'd0);
        check("vr_queue_drained", 32'(exp_vr.size()), 32'd0);
        check("ow_queue_drained", 32'(exp_ow.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
